stage_game_ctrl: RTL and testbench
==================================

# stage_game_ctrl

Parametrised game controller for the shooting-game top level: sequences a configurable number of timed stages, counts goals as BCD score and drives a BCD countdown. It replaces the fixed three-stage controller with a generalised one that adds pause, a dedicated all-cleared end state and per-stage targets and durations. Outputs feed the seven-segment mux and the audio block. Button inputs arrive already debounced and one-pulsed.

## Interface
- NUM_STAGES, 3, number of stages (1..7)
- STAGE_TIME, {8'h20,8'h25,8'h35}, packed 2-digit BCD duration per stage in seconds; stage 1 in LSBs
- STAGE_TARGET, {8'h85,8'h40,8'h15}, packed 2-digit BCD cumulative score needed to clear each stage; stage 1 in LSBs
- PRE_COUNT, 3, pre-stage countdown in seconds (1..9)
- TICK_DIV, 100_000_000, clk cycles per second tick
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  start/continue pulse
- pause  in  1  pause toggle pulse
- back  in  1  abort-to-idle pulse
- goal  in  1  goal sensor pulse
- state_o  out  3  current state encoding
- stage_o  out  3  current stage (0 in IDLE)
- score_o  out  8  cumulative score, 2-digit BCD
- time_o  out  8  remaining seconds, 2-digit BCD
- goal_ack  out  1  one-cycle pulse per accepted goal
- beep  out  1  one-cycle pulse on each PRE tick

## Operation
- States: IDLE=0, PRE=1, PLAY=2, PAUSE=3, WIN=4, LOSE=5, DONE=6.
- IDLE: start -> PRE, stage=1, score=0, time=PRE_COUNT.
- PRE: each tick decrements time and pulses beep; on tick while time==0 -> PLAY, time=STAGE_TIME[stage].
- PLAY: goal -> score+1 (BCD, saturate at 8'h99), goal_ack; tick -> time-1. On tick while time==0: score>=target -> WIN (DONE if stage==NUM_STAGES), else LOSE. pause -> PAUSE.
- PAUSE: prescaler frozen, goals ignored; pause -> PLAY, prescaler resumes from held count.
- WIN: start -> PRE, stage+1, score kept, time=PRE_COUNT.
- LOSE, DONE: start -> IDLE.
- back in any state other than IDLE -> IDLE, stage=0, score=0, time=0.
- Priority per cycle: back > end-of-time > pause > goal accounting; a goal coinciding with the final tick or with pause is counted first and used in the comparison.
- Goals outside PLAY are dropped with no goal_ack.
- BCD arithmetic per digit; time never wraps below 00.

## Timing
- Reset: state_o=0, stage_o=0, score_o=8'h00, time_o=8'h00, goal_ack=0, beep=0, prescaler=0.
- All outputs registered; goal at cycle n -> score_o and goal_ack at n+1.
- Tick is a one-cycle pulse every TICK_DIV cycles. The prescaler clears on every entry to PRE or PLAY from a state other than PAUSE, so the first tick comes exactly TICK_DIV cycles after entry.
- State transitions take effect the cycle after the causing event.
- Reset asserted mid-game returns everything to reset values immediately, without waiting for a clock edge.

## Configuration
- GAME_EARLY_CLEAR_EN defined: in PLAY, reaching score>=target ends the stage on the next cycle (-> WIN/DONE) without waiting for time 00; time_o freezes at its value.
- Undefined: a stage ends only when time expires.

## Structure
- game_pkg: state enum, stage/score widths, bcd_inc and bcd_dec functions, BCD compare function.
- Sub-module tick_gen (TICK_DIV, clear, hold inputs; tick output) for the prescaler.

## Test plan
All scenarios use TICK_DIV=4, NUM_STAGES=3, default targets.
- Reset released, start -> beep 3 times over PRE (time 3,2,1,0), PLAY entered with time_o=8'h35, stage_o=1.
- 15 goals in stage 1, run to expiry -> WIN. Start -> stage_o=2, score_o stays 8'h15.
- 14 goals, then a goal in the same cycle as the final tick -> score_o=8'h15 and WIN.
- Pause in PLAY at time 8'h20, hold 50 cycles with goals -> time_o and score_o unchanged, no goal_ack. Pause again -> countdown resumes.
- Clear all three stages (score 8'h85 at stage 3 expiry) -> DONE. Start -> IDLE.
- Drop rst mid-PLAY between clock edges -> outputs at reset values immediately. With GAME_EARLY_CLEAR_EN, the 15th goal -> WIN within 1 cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and BCD helpers for the stage game controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5,
        ST_DONE  = 3'd6
    } game_state_e;

    localparam int unsigned STAGE_W = 3;
    localparam int unsigned BCD_W   = 8;

    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [BCD_W-1:0]   bcd2_t;

    // Two-digit BCD increment, saturating at 99.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        if (v == 8'h99) return v;
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement, floored at 00.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        if (v == 8'h00) return v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // a >= b for two-digit BCD values, compared digit by digit.
    function automatic logic bcd_ge(input bcd2_t a, input bcd2_t b);
        if (a[7:4] != b[7:4]) return a[7:4] > b[7:4];
        return a[3:0] >= b[3:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV clocks, with
// synchronous clear and a hold input that freezes the count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Tick on the last count; clear wins over both counting and hold.
    always_comb begin
        tick  = !hold && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stage_game_ctrl.sv
// Multi-stage game controller: pre-stage countdown with beeps, timed play
// with BCD score, pause, win/lose/all-cleared end states.
// Optional macro GAME_EARLY_CLEAR_EN: a stage ends as soon as the score
// reaches its target instead of waiting for the countdown to expire.
module stage_game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned               NUM_STAGES   = 3,
    parameter logic [8*NUM_STAGES-1:0]   STAGE_TIME   = {8'h20, 8'h25, 8'h35},
    parameter logic [8*NUM_STAGES-1:0]   STAGE_TARGET = {8'h85, 8'h40, 8'h15},
    parameter int unsigned               PRE_COUNT    = 3,
    parameter int unsigned               TICK_DIV     = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       back,
    input  logic       goal,
    output logic [2:0] state_o,
    output logic [2:0] stage_o,
    output logic [7:0] score_o,
    output logic [7:0] time_o,
    output logic       goal_ack,
    output logic       beep
);

    game_state_e state_q, state_d;
    stage_t      stage_q, stage_d;
    bcd2_t       score_q, score_d;
    bcd2_t       time_q,  time_d;
    logic        goal_ack_q, goal_ack_d;
    logic        beep_q, beep_d;

    logic        tick;
    logic        tick_clear;
    logic        tick_hold;
    logic        last_stage;
    logic        cleared;

    function automatic bcd2_t stage_time_of(input stage_t s);
        bcd2_t r = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (32'(s) == i + 1) r = STAGE_TIME[8*i +: 8];
        end
        return r;
    endfunction

    function automatic bcd2_t stage_target_of(input stage_t s);
        bcd2_t r = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (32'(s) == i + 1) r = STAGE_TARGET[8*i +: 8];
        end
        return r;
    endfunction

    assign tick_hold  = (state_q == ST_PAUSE);
    assign last_stage = (stage_q == STAGE_W'(NUM_STAGES));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .hold  (tick_hold),
        .tick  (tick)
    );

    // Next-state and datapath; goal accounting precedes the end-of-stage
    // compare so a goal on the final tick (or with pause) still counts.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        score_d    = score_q;
        time_d     = time_q;
        goal_ack_d = 1'b0;
        beep_d     = 1'b0;
        cleared    = 1'b0;

        if (back && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            stage_d = '0;
            score_d = '0;
            time_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PRE;
                        stage_d = STAGE_W'(1);
                        score_d = '0;
                        time_d  = BCD_W'(PRE_COUNT);
                    end
                end
                ST_PRE: begin
                    if (tick) begin
                        if (time_q == 8'h00) begin
                            state_d = ST_PLAY;
                            time_d  = stage_time_of(stage_q);
                        end else begin
                            time_d = bcd_dec(time_q);
                            beep_d = 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (goal) begin
                        score_d    = bcd_inc(score_q);
                        goal_ack_d = 1'b1;
                    end
                    cleared = bcd_ge(score_d, stage_target_of(stage_q));
                    if (tick && time_q == 8'h00) begin
                        if (cleared) state_d = last_stage ? ST_DONE : ST_WIN;
                        else         state_d = ST_LOSE;
`ifdef GAME_EARLY_CLEAR_EN
                    end else if (cleared) begin
                        state_d = last_stage ? ST_DONE : ST_WIN;
`endif
                    end else begin
                        if (tick)  time_d  = bcd_dec(time_q);
                        if (pause) state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause) state_d = ST_PLAY;
                end
                ST_WIN: begin
                    if (start) begin
                        state_d = ST_PRE;
                        stage_d = stage_q + STAGE_W'(1);
                        time_d  = BCD_W'(PRE_COUNT);
                    end
                end
                ST_LOSE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                        score_d = '0;
                        time_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        tick_clear = (state_d == ST_PRE || state_d == ST_PLAY) &&
                     (state_d != state_q) && (state_q != ST_PAUSE);
    end

    // Registered state and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            score_q    <= '0;
            time_q     <= '0;
            goal_ack_q <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            score_q    <= score_d;
            time_q     <= time_d;
            goal_ack_q <= goal_ack_d;
            beep_q     <= beep_d;
        end
    end

    assign state_o  = state_q;
    assign stage_o  = stage_q;
    assign score_o  = score_q;
    assign time_o   = time_q;
    assign goal_ack = goal_ack_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_stage_game_ctrl.sv
// Scoreboard bench for stage_game_ctrl: an integer-level game model predicts
// every cycle's outputs into a queue; a negedge monitor compares them.
module tb_stage_game_ctrl;

    localparam int TICK_DIV = 4;
    localparam int NS       = 3;
    localparam int PRE      = 3;
`ifdef GAME_EARLY_CLEAR_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, pause, back, goal;
    logic [2:0] state_o, stage_o;
    logic [7:0] score_o, time_o;
    logic       goal_ack, beep;

    stage_game_ctrl #(
        .NUM_STAGES (NS),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .back     (back),
        .goal     (goal),
        .state_o  (state_o),
        .stage_o  (stage_o),
        .score_o  (score_o),
        .time_o   (time_o),
        .goal_ack (goal_ack),
        .beep     (beep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] stg;
        logic [7:0] sc;
        logic [7:0] tm;
        logic       ack;
        logic       bp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game rules in decimal; stage tables straight from the stage list.
    int stime[3] = '{35, 25, 20};
    int tgt[3]   = '{15, 40, 85};
    int m_state = 0, m_stage = 0, m_score = 0, m_time = 0, m_elapsed = 0;
    bit m_ack = 0, m_beep = 0;
    bit m_tick, m_restart, m_counting, m_cleared;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Reference model: advance one clock and predict the registered outputs.
    always @(posedge clk) begin
        exp_t e;
        if (!rst) begin
            m_state = 0; m_stage = 0; m_score = 0; m_time = 0;
            m_elapsed = 0; m_ack = 0; m_beep = 0;
        end else begin
            m_counting = (m_state == 1 || m_state == 2);
            m_tick     = m_counting && ((m_elapsed + 1) % TICK_DIV == 0);
            m_restart  = 0; m_ack = 0; m_beep = 0;
            if (back && m_state != 0) begin
                m_state = 0; m_stage = 0; m_score = 0; m_time = 0;
            end else begin
                case (m_state)
                    0: if (start) begin
                        m_state = 1; m_stage = 1; m_score = 0; m_time = PRE; m_restart = 1;
                    end
                    1: if (m_tick) begin
                        if (m_time == 0) begin
                            m_state = 2; m_time = stime[m_stage-1]; m_restart = 1;
                        end else begin
                            m_time = m_time - 1; m_beep = 1;
                        end
                    end
                    2: begin
                        if (goal) begin
                            m_score = (m_score < 99) ? m_score + 1 : 99;
                            m_ack = 1;
                        end
                        m_cleared = m_score >= tgt[m_stage-1];
                        if (m_tick && m_time == 0)
                            m_state = m_cleared ? ((m_stage == NS) ? 6 : 4) : 5;
                        else if (EARLY && m_cleared)
                            m_state = (m_stage == NS) ? 6 : 4;
                        else begin
                            if (m_tick) m_time = m_time - 1;
                            if (pause) m_state = 3;
                        end
                    end
                    3: if (pause) m_state = 2;
                    4: if (start) begin
                        m_state = 1; m_stage = m_stage + 1; m_time = PRE; m_restart = 1;
                    end
                    default: if (start) begin
                        m_state = 0; m_stage = 0; m_score = 0; m_time = 0;
                    end
                endcase
            end
            if (m_restart) m_elapsed = 0;
            else if (m_counting) m_elapsed = m_elapsed + 1;
        end
        e.st  = 3'(m_state);
        e.stg = 3'(m_stage);
        e.sc  = to_bcd(m_score);
        e.tm  = to_bcd(m_time);
        e.ack = m_ack;
        e.bp  = m_beep;
        exp_q.push_back(e);
    end

    // Monitor: compare each presented output set against the prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({state_o, stage_o, score_o, time_o, goal_ack, beep} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got st=%0d stg=%0d sc=%h tm=%h ack=%b bp=%b, expected st=%0d stg=%0d sc=%h tm=%h ack=%b bp=%b",
                         $time, state_o, stage_o, score_o, time_o, goal_ack, beep,
                         e.st, e.stg, e.sc, e.tm, e.ack, e.bp);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic b, input logic g);
        start = s; pause = p; back = b; goal = g;
        @(posedge clk); #2;
        start = 0; pause = 0; back = 0; goal = 0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state_o !== st && n < budget) begin
            step(0, 0, 0, 0);
            n++;
        end
        check(name, 8'(state_o), 8'(st));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 8'(state_o), 8'h00);
        check({tag, "_stage"}, 8'(stage_o), 8'h00);
        check({tag, "_score"}, score_o, 8'h00);
        check({tag, "_time"},  time_o,  8'h00);
        check({tag, "_ack"},   8'(goal_ack), 8'h00);
        check({tag, "_beep"},  8'(beep), 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beeps, acks, n;
        rst = 0; start = 0; pause = 0; back = 0; goal = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        rst = 1;
        step(0, 0, 0, 0);

        // Stage 1: pre-countdown beeps, then 15 goals and expiry.
        step(1, 0, 0, 0);
        beeps = 0; n = 0;
        while (state_o !== 3'd2 && n < 40) begin
            step(0, 0, 0, 0);
            if (beep) beeps++;
            n++;
        end
        check("pre_beeps", 8'(beeps), 8'd3);
        check("play1_state", 8'(state_o), 8'd2);
        check("play1_time", time_o, 8'h35);
        check("play1_stage", 8'(stage_o), 8'd1);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 1);
            if (i < 14) step(0, 0, 0, 0);
        end
        check("goal15_state", 8'(state_o), EARLY ? 8'd4 : 8'd2);
        wait_state(3'd4, 300, "stage1_win");
        check("stage1_score", score_o, 8'h15);
        step(1, 0, 0, 0);
        check("stage2_stage", 8'(stage_o), 8'd2);
        check("stage2_score_kept", score_o, 8'h15);

        // Stage 2: 24 goals, then the 25th on the final tick.
        wait_state(3'd2, 40, "play2");
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        n = 0;
        while (time_o !== 8'h00 && n < 200) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("stage2_time_zero", time_o, 8'h00);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("final_tick_goal_state", 8'(state_o), 8'd4);
        check("final_tick_goal_score", score_o, 8'h40);

        // Stage 3: pause at 20 s with goals held off, resume, clear all.
        step(1, 0, 0, 0);
        wait_state(3'd2, 40, "play3");
        check("play3_time", time_o, 8'h20);
        step(0, 1, 0, 0);
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 1'($urandom_range(0, 1)));
            if (goal_ack) acks++;
        end
        check("pause_state", 8'(state_o), 8'd3);
        check("pause_time", time_o, 8'h20);
        check("pause_score", score_o, 8'h40);
        check("pause_acks", 8'(acks), 8'd0);
        step(0, 1, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        check("resume_time", time_o, 8'h17);
        repeat (45) step(0, 0, 0, 1);
        wait_state(3'd6, 200, "all_done");
        check("done_score", score_o, 8'h85);
        check("done_stage", 8'(stage_o), 8'd3);
        step(1, 0, 0, 0);
        check("done_to_idle", 8'(state_o), 8'd0);

        // Score saturation at 99, then abort with back.
        step(1, 0, 0, 0);
        wait_state(3'd2, 40, "play_sat");
        repeat (105) step(0, 0, 0, 1);
        check("sat_score", score_o, EARLY ? 8'h15 : 8'h99);
        step(0, 0, 1, 0);
        check_reset_vals("back");

        // Asynchronous reset in the middle of a clock period during PLAY.
        step(1, 0, 0, 0);
        wait_state(3'd2, 40, "play_arst");
        repeat (5) step(0, 0, 0, 1);
        rst = 0;
        #1;
        check_reset_vals("arst");
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1;
        step(0, 0, 0, 0);

        // Lose: too few goals for stage 1.
        step(1, 0, 0, 0);
        wait_state(3'd2, 40, "play_lose");
        repeat (3) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        wait_state(3'd5, 300, "lose_state");
        check("lose_score", score_o, 8'h03);
        step(1, 0, 0, 0);
        check("lose_to_idle", 8'(state_o), 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 999) < 4), 1'($urandom_range(0, 99) < 35));
        end

        repeat (3) step(0, 0, 0, 0);
        check("queue_drained", 8'(exp_q.size() > 1), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
